// File: rtl/stack_pkg.sv
// Shared definitions for the stack-access sequencer: opcodes, FSM states,
// and the per-opcode access-count / direction table.
package stack_pkg;

    typedef enum logic [2:0] {
        STK_PUSH1    = 3'd0,
        STK_PULL1    = 3'd1,
        STK_PUSH_RET = 3'd2,
        STK_PULL_RET = 3'd3,
        STK_PUSH_INT = 3'd4,
        STK_PULL_RTI = 3'd5,
        STK_RSV6     = 3'd6,
        STK_RSV7     = 3'd7
    } stk_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } stk_state_e;

    // Number of bus accesses an opcode performs; nb is the PC byte count.
    function automatic int op_count(input stk_op_e op, input int nb);
        case (op)
            STK_PUSH1, STK_PULL1:       return 1;
            STK_PUSH_RET, STK_PULL_RET: return nb;
            STK_PUSH_INT, STK_PULL_RTI: return nb + 1;
            default:                    return 0;
        endcase
    endfunction

    // Direction of every access of an opcode: 1 = read (pull), 0 = write (push).
    function automatic logic op_is_read(input stk_op_e op);
        case (op)
            STK_PULL1, STK_PULL_RET, STK_PULL_RTI: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/stack_seq_if.sv
// Command, result and stack-bus signals of the stack sequencer.
// slave = the sequencer; master = the core/bus side that drives commands
// and returns read data.
interface stack_seq_if #(
    parameter int ADDR_W = 16,
    parameter int SP_W   = 8
);
    logic              cmd_valid;
    logic [2:0]        cmd_op;
    logic              cmd_ready;
    logic [ADDR_W-1:0] pc_in;
    logic [7:0]        p_in;
    logic [7:0]        byte_in;
    logic              sp_load;
    logic [SP_W-1:0]   sp_wdata;
    logic [SP_W-1:0]   sp_out;
    logic              bus_en;
    logic              bus_rw;
    logic [ADDR_W-1:0] bus_addr;
    logic [7:0]        bus_dout;
    logic [7:0]        bus_din;
    logic              done;
    logic [ADDR_W-1:0] result_pc;
    logic [7:0]        result_p;
    logic [7:0]        result_byte;

    modport master (
        output cmd_valid, cmd_op, pc_in, p_in, byte_in, sp_load, sp_wdata, bus_din,
        input  cmd_ready, sp_out, bus_en, bus_rw, bus_addr, bus_dout,
               done, result_pc, result_p, result_byte
    );

    modport slave (
        input  cmd_valid, cmd_op, pc_in, p_in, byte_in, sp_load, sp_wdata, bus_din,
        output cmd_ready, sp_out, bus_en, bus_rw, bus_addr, bus_dout,
               done, result_pc, result_p, result_byte
    );
endinterface

// File: rtl/stack_ptr.sv
// Stack pointer register with load/increment/decrement and stack address
// formation. Pulls pre-increment, so a read addresses SP+1 in the same
// cycle that the register advances to it.
module stack_ptr #(
    parameter int ADDR_W     = 16,
    parameter int SP_W       = 8,
    parameter int STACK_PAGE = 1,
    parameter int SP_RESET   = 'hFD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [SP_W-1:0]   wdata,
    input  logic              inc,
    input  logic              dec,
    input  logic              rd,
    output logic [SP_W-1:0]   sp,
    output logic [ADDR_W-1:0] addr
);
    localparam logic [ADDR_W-SP_W-1:0] PAGE = (ADDR_W-SP_W)'(STACK_PAGE);

    logic [SP_W-1:0] sp_reg;
    logic [SP_W-1:0] sp_plus1;

    assign sp_plus1 = sp_reg + SP_W'(1);

    // SP update; arithmetic wraps inside the page by construction of the width.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sp_reg <= SP_W'(SP_RESET);
        else if (load)
            sp_reg <= wdata;
        else if (inc)
            sp_reg <= sp_plus1;
        else if (dec)
            sp_reg <= sp_reg - SP_W'(1);
    end

    assign sp   = sp_reg;
    assign addr = {PAGE, (rd ? sp_plus1 : sp_reg)};
endmodule

// File: rtl/stack_seq.sv
// Stack-access sequencer: owns SP and runs multi-byte push/pull sequences
// as one stack-bus access per cycle, returning assembled PC/P/byte results.
module stack_seq
    import stack_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int SP_W       = 8,
    parameter int STACK_PAGE = 1,
    parameter int SP_RESET   = 'hFD
) (
    input  logic       clk,
    input  logic       reset,
    stack_seq_if.slave sif
);
    localparam int NB  = (ADDR_W + 7) / 8;   // PC bytes
    localparam int SHW = (NB + 1) * 8;       // push shifter: PC bytes + P
    localparam int KW  = $clog2(NB + 2);

    stk_state_e        state_reg, state_next;
    logic [KW-1:0]     k_reg, k_next;
    logic              done_reg, done_next;
    stk_op_e           op_reg;
    logic [SHW-1:0]    sh_reg, sh_load;
    logic [NB*8-1:0]   acc_reg, acc_next, pc_ext;
    logic [ADDR_W-1:0] result_pc_reg;
    logic [7:0]        result_p_reg, result_byte_reg;

    logic              accept, xfer, is_rd, last, first;
    logic [KW-1:0]     start_cnt;
    logic [ADDR_W-1:0] sp_addr;

    assign accept    = sif.cmd_valid && (state_reg == ST_IDLE);
    assign xfer      = (state_reg == ST_XFER);
    assign is_rd     = op_is_read(op_reg);
    assign last      = (k_reg == KW'(1));
    assign first     = (k_reg == KW'(NB + 1));
    assign start_cnt = KW'(op_count(stk_op_e'(sif.cmd_op), NB));
    assign acc_next  = {sif.bus_din, acc_reg[NB*8-1:8]};

    stack_ptr #(
        .ADDR_W    (ADDR_W),
        .SP_W      (SP_W),
        .STACK_PAGE(STACK_PAGE),
        .SP_RESET  (SP_RESET)
    ) u_sp (
        .clk  (clk),
        .reset(reset),
        .load (sif.sp_load && (state_reg == ST_IDLE)),
        .wdata(sif.sp_wdata),
        .inc  (xfer && is_rd),
        .dec  (xfer && !is_rd),
        .rd   (is_rd),
        .sp   (sif.sp_out),
        .addr (sp_addr)
    );

    // FSM state, remaining-access counter and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            k_reg     <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            done_reg  <= done_next;
        end
    end

    // Next state: zero-access (reserved) ops finish straight from IDLE.
    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (start_cnt != '0) begin
                        state_next = ST_XFER;
                        k_next     = start_cnt;
                    end else begin
                        done_next  = 1'b1;
                    end
                end
            end
            ST_XFER: begin
                k_next = k_reg - KW'(1);
                if (last) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Push byte order: PC most-significant first, then P for interrupts.
    always_comb begin
        pc_ext              = '0;
        pc_ext[ADDR_W-1:0]  = sif.pc_in;
        sh_load             = '0;
        case (stk_op_e'(sif.cmd_op))
            STK_PUSH1:    sh_load[SHW-1 -: 8]    = sif.byte_in;
            STK_PUSH_RET: sh_load[SHW-1 -: NB*8] = pc_ext;
            STK_PUSH_INT: sh_load                = {pc_ext, sif.p_in};
            default:      sh_load                = '0;
        endcase
    end

    // Capture command operands at accept; shift out one byte per write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_reg <= STK_PUSH1;
            sh_reg <= '0;
        end else if (accept) begin
            op_reg <= stk_op_e'(sif.cmd_op);
            sh_reg <= sh_load;
        end else if (xfer && !is_rd) begin
            sh_reg <= sh_reg << 8;
        end
    end

    // Assemble pulled bytes; PC bytes arrive least-significant first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg         <= '0;
            result_pc_reg   <= '0;
            result_p_reg    <= '0;
            result_byte_reg <= '0;
        end else if (xfer && is_rd) begin
            acc_reg <= acc_next;
            case (op_reg)
                STK_PULL1: result_byte_reg <= sif.bus_din;
                STK_PULL_RET: begin
                    if (last)
                        result_pc_reg <= acc_next[ADDR_W-1:0] + ADDR_W'(1);
                end
                STK_PULL_RTI: begin
                    if (first)
                        result_p_reg <= sif.bus_din;
                    if (last)
                        result_pc_reg <= acc_next[ADDR_W-1:0];
                end
                default: ;
            endcase
        end
    end

    assign sif.cmd_ready   = (state_reg == ST_IDLE);
    assign sif.bus_en      = xfer;
    assign sif.bus_rw      = !(xfer && !is_rd);
    assign sif.bus_addr    = xfer ? sp_addr : '0;
    assign sif.bus_dout    = (xfer && !is_rd) ? sh_reg[SHW-1 -: 8] : 8'h00;
    assign sif.done        = done_reg;
    assign sif.result_pc   = result_pc_reg;
    assign sif.result_p    = result_p_reg;
    assign sif.result_byte = result_byte_reg;
endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq: table of commands with hand-computed bus
// accesses and results, plus hand-written back-to-back and mid-op reset cases.
module tb_stack_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    stack_seq_if #(.ADDR_W(16), .SP_W(8)) sif ();

    stack_seq #(.ADDR_W(16), .SP_W(8), .STACK_PAGE(1), .SP_RESET('hFD)) dut (
        .clk  (clk),
        .reset(reset),
        .sif  (sif.slave)
    );

    // Byte-wide memory model behind the stack bus, with a preload port.
    logic [7:0]  mem [0:65535];
    logic        pre_en = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    assign sif.bus_din = mem[sif.bus_addr];
    always @(posedge clk) begin
        if (pre_en)
            mem[pre_addr] <= pre_data;
        else if (sif.bus_en && !sif.bus_rw)
            mem[sif.bus_addr] <= sif.bus_dout;
    end

    typedef struct packed {
        logic [2:0]       op;
        logic             ld;
        logic [7:0]       ld_sp;
        logic [15:0]      pc;
        logic [7:0]       p;
        logic [7:0]       b;
        logic [1:0]       nacc;
        logic             rw;
        logic [2:0][15:0] addr;
        logic [2:0][7:0]  wd;
        logic [7:0]       e_sp;
        logic [15:0]      e_pc;
        logic [7:0]       e_p;
        logic [7:0]       e_b;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    function automatic vec_t mk(
        input logic [2:0] op, input logic ld, input logic [7:0] ld_sp,
        input logic [15:0] pc, input logic [7:0] p, input logic [7:0] b,
        input logic [1:0] nacc, input logic rw,
        input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
        input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
        input logic [7:0] e_sp, input logic [15:0] e_pc,
        input logic [7:0] e_p, input logic [7:0] e_b);
        vec_t v;
        v.op = op; v.ld = ld; v.ld_sp = ld_sp; v.pc = pc; v.p = p; v.b = b;
        v.nacc = nacc; v.rw = rw;
        v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2;
        v.wd[0] = d0; v.wd[1] = d1; v.wd[2] = d2;
        v.e_sp = e_sp; v.e_pc = e_pc; v.e_p = e_p; v.e_b = e_b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        sif.cmd_valid = 1'b0;
        sif.cmd_op    = 3'd0;
        sif.pc_in     = '0;
        sif.p_in      = '0;
        sif.byte_in   = '0;
        sif.sp_load   = 1'b0;
        sif.sp_wdata  = '0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    // Issue one command, check every access cycle and the done cycle.
    task automatic run_vec(input vec_t v, input int id);
        @(negedge clk);
        chk("cmd_ready", 32'(sif.cmd_ready), 32'd1);
        sif.cmd_valid = 1'b1;
        sif.cmd_op    = v.op;
        sif.pc_in     = v.pc;
        sif.p_in      = v.p;
        sif.byte_in   = v.b;
        sif.sp_load   = v.ld;
        sif.sp_wdata  = v.ld_sp;
        @(negedge clk);
        sif.cmd_valid = 1'b0;
        sif.sp_load   = 1'b0;
        sif.pc_in     = ~v.pc;
        sif.p_in      = ~v.p;
        sif.byte_in   = ~v.b;
        for (int i = 0; i < int'(v.nacc); i++) begin
            chk("bus_en", 32'(sif.bus_en), 32'd1);
            chk("bus_rw", 32'(sif.bus_rw), 32'(v.rw));
            chk("bus_addr", 32'(sif.bus_addr), 32'(v.addr[i]));
            if (!v.rw)
                chk("bus_dout", 32'(sif.bus_dout), 32'(v.wd[i]));
            chk("done_early", 32'(sif.done), 32'd0);
            @(negedge clk);
        end
        chk("done", 32'(sif.done), 32'd1);
        chk("bus_en_idle", 32'(sif.bus_en), 32'd0);
        chk("bus_rw_idle", 32'(sif.bus_rw), 32'd1);
        chk("sp_out", 32'(sif.sp_out), 32'(v.e_sp));
        chk("result_pc", 32'(sif.result_pc), 32'(v.e_pc));
        chk("result_p", 32'(sif.result_p), 32'(v.e_p));
        chk("result_byte", 32'(sif.result_byte), 32'(v.e_b));
        $display("vec %0d op=%0d sp=%h pc=%h p=%h byte=%h", id, v.op,
                 sif.sp_out, sif.result_pc, sif.result_p, sif.result_byte);
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = mk(3'd3, 1, 8'hFD, 16'h0000, 8'h00, 8'h00, 2'd2, 1,
                     16'h01FE, 16'h01FF, 16'h0000, 8'h00, 8'h00, 8'h00,
                     8'hFF, 16'h5597, 8'h00, 8'h00);
        vecs[1] = mk(3'd2, 1, 8'hFF, 16'h1234, 8'h00, 8'h00, 2'd2, 0,
                     16'h01FF, 16'h01FE, 16'h0000, 8'h12, 8'h34, 8'h00,
                     8'hFD, 16'h5597, 8'h00, 8'h00);
        vecs[2] = mk(3'd0, 1, 8'h00, 16'h0000, 8'h00, 8'hA5, 2'd1, 0,
                     16'h0100, 16'h0000, 16'h0000, 8'hA5, 8'h00, 8'h00,
                     8'hFF, 16'h5597, 8'h00, 8'h00);
        vecs[3] = mk(3'd1, 0, 8'h00, 16'h0000, 8'h00, 8'h00, 2'd1, 1,
                     16'h0100, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00,
                     8'h00, 16'h5597, 8'h00, 8'hA5);
        vecs[4] = mk(3'd4, 1, 8'hFF, 16'hABCD, 8'h24, 8'h00, 2'd3, 0,
                     16'h01FF, 16'h01FE, 16'h01FD, 8'hAB, 8'hCD, 8'h24,
                     8'hFC, 16'h5597, 8'h00, 8'hA5);
        vecs[5] = mk(3'd5, 0, 8'h00, 16'h0000, 8'h00, 8'h00, 2'd3, 1,
                     16'h01FD, 16'h01FE, 16'h01FF, 8'h00, 8'h00, 8'h00,
                     8'hFF, 16'hABCD, 8'h24, 8'hA5);
        vecs[6] = mk(3'd2, 1, 8'hFF, 16'hFFFF, 8'h00, 8'h00, 2'd2, 0,
                     16'h01FF, 16'h01FE, 16'h0000, 8'hFF, 8'hFF, 8'h00,
                     8'hFD, 16'hABCD, 8'h24, 8'hA5);
        vecs[7] = mk(3'd3, 0, 8'h00, 16'h0000, 8'h00, 8'h00, 2'd2, 1,
                     16'h01FE, 16'h01FF, 16'h0000, 8'h00, 8'h00, 8'h00,
                     8'hFF, 16'h0000, 8'h24, 8'hA5);
        vecs[8] = mk(3'd6, 0, 8'h00, 16'h1111, 8'h22, 8'h33, 2'd0, 1,
                     16'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00,
                     8'hFF, 16'h0000, 8'h24, 8'hA5);
        vecs[9] = mk(3'd0, 1, 8'h80, 16'h0000, 8'h00, 8'h3C, 2'd1, 0,
                     16'h0180, 16'h0000, 16'h0000, 8'h3C, 8'h00, 8'h00,
                     8'h7F, 16'h0000, 8'h24, 8'hA5);

        idle_inputs();
        // Reset state while reset is held; preload the RTS frame meanwhile.
        @(negedge clk);
        chk("rst_sp", 32'(sif.sp_out), 32'h00FD);
        chk("rst_bus_en", 32'(sif.bus_en), 32'd0);
        chk("rst_bus_rw", 32'(sif.bus_rw), 32'd1);
        chk("rst_bus_addr", 32'(sif.bus_addr), 32'd0);
        chk("rst_bus_dout", 32'(sif.bus_dout), 32'd0);
        chk("rst_done", 32'(sif.done), 32'd0);
        chk("rst_result_pc", 32'(sif.result_pc), 32'd0);
        chk("rst_result_p", 32'(sif.result_p), 32'd0);
        chk("rst_result_byte", 32'(sif.result_byte), 32'd0);
        chk("rst_ready", 32'(sif.cmd_ready), 32'd1);
        preload(16'h01FE, 8'h96);
        preload(16'h01FF, 8'h55);
        reset = 1'b1;

        for (int i = 0; i < 10; i++)
            run_vec(vecs[i], i);

        // Back-to-back: PUSH1 with sp_load while busy, PULL1 accepted in done cycle.
        @(negedge clk);
        sif.cmd_valid = 1'b1;
        sif.cmd_op    = 3'd0;
        sif.byte_in   = 8'h11;
        @(negedge clk);
        sif.cmd_valid = 1'b0;
        sif.sp_load   = 1'b1;
        sif.sp_wdata  = 8'h00;
        chk("b2b_push_addr", 32'(sif.bus_addr), 32'h017F);
        chk("b2b_push_dout", 32'(sif.bus_dout), 32'h0011);
        chk("b2b_push_rw", 32'(sif.bus_rw), 32'd0);
        @(negedge clk);
        sif.sp_load = 1'b0;
        chk("b2b_done1", 32'(sif.done), 32'd1);
        chk("b2b_sp_busy_load", 32'(sif.sp_out), 32'h007E);
        chk("b2b_ready", 32'(sif.cmd_ready), 32'd1);
        sif.cmd_valid = 1'b1;
        sif.cmd_op    = 3'd1;
        @(negedge clk);
        sif.cmd_valid = 1'b0;
        chk("b2b_pull_en", 32'(sif.bus_en), 32'd1);
        chk("b2b_pull_rw", 32'(sif.bus_rw), 32'd1);
        chk("b2b_pull_addr", 32'(sif.bus_addr), 32'h017F);
        @(negedge clk);
        chk("b2b_done2", 32'(sif.done), 32'd1);
        chk("b2b_byte", 32'(sif.result_byte), 32'h0011);
        chk("b2b_sp", 32'(sif.sp_out), 32'h007F);
        $display("b2b push/pull sp=%h byte=%h", sif.sp_out, sif.result_byte);

        // Reset during the first access of PUSH_INT.
        @(negedge clk);
        sif.cmd_valid = 1'b1;
        sif.cmd_op    = 3'd4;
        sif.pc_in     = 16'h4321;
        sif.p_in      = 8'h77;
        sif.sp_load   = 1'b1;
        sif.sp_wdata  = 8'hFF;
        @(negedge clk);
        idle_inputs();
        chk("rop_bus_en_before", 32'(sif.bus_en), 32'd1);
        reset = 1'b0;
        #1;
        chk("rop_bus_en", 32'(sif.bus_en), 32'd0);
        chk("rop_bus_rw", 32'(sif.bus_rw), 32'd1);
        chk("rop_sp", 32'(sif.sp_out), 32'h00FD);
        chk("rop_done", 32'(sif.done), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rop_no_done", 32'(sif.done), 32'd0);
            chk("rop_no_bus", 32'(sif.bus_en), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rop_no_done_after", 32'(sif.done), 32'd0);
        chk("rop_mem_untouched", 32'(mem[16'h01FF]), 32'h00FF);
        $display("reset mid-op sp=%h", sif.sp_out);
        run_vec(mk(3'd1, 0, 8'h00, 16'h0000, 8'h00, 8'h00, 2'd1, 1,
                   16'h01FE, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00,
                   8'hFE, 16'h0000, 8'h00, 8'hFF), 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Parametrised stack-access sequencer for the cpu6502 core family. It generalises the fixed page-1, 8-bit-SP stack behaviour of the current core.
- Owns the stack pointer and executes multi-byte stack operations (JSR/RTS/RTI/interrupt/PHA/PLA style) as one bus access per cycle.
- Returns the assembled PC/P/byte results to the core.
- Sits between the instruction decoder and the shared address/data bus mux.

Parameters:
- ADDR_W, 16, bus address width.
- SP_W, 8, stack pointer width; the stack occupies one page of 2^SP_W bytes.
- STACK_PAGE, 1, page number (width ADDR_W-SP_W) forming the upper address bits.
- SP_RESET, 'hFD, SP value after reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- cmd_valid  in  1  command request.
- cmd_op  in  3  0 PUSH1, 1 PULL1, 2 PUSH_RET, 3 PULL_RET, 4 PUSH_INT, 5 PULL_RTI; 6-7 reserved.
- cmd_ready  out  1  high when the block can accept a command.
- pc_in  in  ADDR_W  PC to push.
- p_in  in  8  status byte to push (PUSH_INT).
- byte_in  in  8  data byte to push (PUSH1).
- sp_load  in  1  load SP from sp_wdata (TXS).
- sp_wdata  in  SP_W  new SP value.
- sp_out  out  SP_W  current SP.
- bus_en  out  1  access active this cycle.
- bus_rw  out  1  1 = read, 0 = write.
- bus_addr  out  ADDR_W  {STACK_PAGE, sp_access}.
- bus_dout  out  8  write data.
- bus_din  in  8  read data, valid combinationally in the same cycle as bus_addr.
- done  out  1  one-cycle pulse; results valid.
- result_pc  out  ADDR_W  pulled PC (PULL_RET adds 1).
- result_p  out  8  pulled status (PULL_RTI).
- result_byte  out  8  pulled byte (PULL1).

Behaviour:
- Reset (reset=0, async):
  - State IDLE, sp_out=SP_RESET.
  - bus_en=0, bus_rw=1, bus_addr=0, bus_dout=0.
  - done=0; result_pc, result_p and result_byte are all 0.
  - Reset mid-operation abandons the sequence. No further bus accesses occur and no done pulse is produced.
- cmd_ready = (state == IDLE). Accept happens when cmd_valid && cmd_ready.
- sp_load:
  - Honoured only in IDLE.
  - If sp_load and accept occur in the same cycle, the loaded value is used as the starting SP of the command.
  - Ignored while busy.
- Access rules (6502 semantics, all SP arithmetic modulo 2^SP_W, address never leaves STACK_PAGE):
  - Push: write at {page,SP}, then SP-1.
  - Pull: SP+1, then read at {page,SP}.
- Sequences, one access per cycle starting the cycle after accept:
  - PUSH1: write byte_in. 1 access.
  - PULL1: read into result_byte. 1 access.
  - PUSH_RET: write pc_in[hi], then pc_in[lo]. 2 accesses.
  - PULL_RET: read lo, then hi. result_pc = {hi,lo}+1, wrapping modulo 2^ADDR_W. 2 accesses.
  - PUSH_INT: write pc hi, pc lo, p_in. 3 accesses.
  - PULL_RTI: read P, lo, hi. result_pc = {hi,lo} with no +1. 3 accesses.
  - For ADDR_W>16, PC bytes are pushed most-significant first and pulled least-significant first; byte count = ceil(ADDR_W/8).
- pc_in, p_in and byte_in are captured at accept; later changes have no effect.
- Read data is sampled at the rising edge ending each read cycle.
- FSM states: IDLE -> XFER (byte counter k counts down) -> IDLE.
  - done=1 in the first IDLE cycle after the last access.
  - sp_out already shows the final value in that cycle.
  - A new command may be accepted in the done cycle.
- Latency: accept at cycle N; accesses at N+1..N+k; done at N+k+1.
- Reserved opcodes are accepted, perform no access, leave SP unchanged, and pulse done at N+1.
- Outside XFER: bus_en=0 and bus_rw=1.
- Result registers hold their values until overwritten by a later pull.

Decomposition:
- Package stack_pkg holds:
  - cmd_op encodings (STK_PUSH1 … STK_PULL_RTI).
  - FSM state encodings.
  - Per-op access count and direction table.
- One sub-module is natural: stack_ptr, which holds the SP register, load/inc/dec logic, wrap handling and address formation.

Test Plan:
- RTS: sp_load FD at N-1 with mem[01FE]=96, mem[01FF]=55. PULL_RET at N -> reads 01FE at N+1 and 01FF at N+2; done at N+3 with result_pc=5597 and sp_out=FF.
- JSR: SP=FF, pc_in=1234, PUSH_RET -> write 01FF=12 at N+1, write 01FE=34 at N+2; done at N+3 with sp_out=FD.
- Wrap: SP=00, PUSH1 byte_in=A5 -> write 0100=A5 and sp_out=FF. Then PULL1 -> reads 0100, result_byte=A5, sp_out=00.
- Interrupt round trip: SP=FF, PUSH_INT with pc_in=ABCD and p_in=24 -> writes 01FF=AB, 01FE=CD, 01FD=24. Then PULL_RTI -> result_p=24, result_pc=ABCD, sp_out=FF.
- PC wrap: stack holds FFFF, PULL_RET -> result_pc=0000.
- Reset mid-op: assert reset at N+1 of PUSH_INT -> bus_en=0 immediately, sp_out=FD, no done. After release, a PULL1 completes normally.
